mult_div_sequencer: RTL and testbench

Sequences the shared iterative multiply/divide resource for the multicycle MIPS core, covering the MULT, DIV, MFHI and MFLO instructions.
- Accepts one start pulse from the control unit.
- Runs a 32-iteration signed shift-add multiply or restoring divide.
- Commits the result to the HI/LO registers.
- Reports busy/done/div-by-zero back to the control unit, which stalls in its wait state until done.

---
 rtl/mdu_pkg.sv | 7 +
 rtl/mult_div_sequencer_if.sv | 14 +
 rtl/mdu_step_unit.sv | 24 ++
 rtl/mult_div_sequencer.sv | 100 ++++++++++
 tb/tb_mult_div_sequencer.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide sequencer.
package mdu_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [2:0] {IDLE, MULT_RUN, DIV_RUN, SIGN_FIX, DONE} state_t;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
endpackage

// File: rtl/mult_div_sequencer_if.sv
// mult_div_sequencer_if: control-unit handshake and HI/LO result bus.
interface mult_div_sequencer_if #(parameter int WIDTH = mdu_pkg::WIDTH);
  logic start_mult;
  logic start_div;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic busy;
  logic done;
  logic div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start_mult, start_div, rs, rt, input busy, done, div_zero, hi, lo);
  modport slave(input start_mult, start_div, rs, rt, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mdu_step_unit.sv
// mdu_step_unit: one shift-add multiply or restoring divide iteration on magnitudes.
module mdu_step_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = mdu_pkg::WIDTH
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;
  // multiply keeps the multiplier in the low half and retires one bit per step
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem = acc[2*WIDTH-1:WIDTH-1];
    diff = rem - {1'b0, operand};
    acc_next = (op == OP_MULT) ? {sum, acc[WIDTH-1:1]} :
               diff[WIDTH] ? {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
               {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: FSM driving the iterative MULT/DIV datapath and HI/LO registers.
module mult_div_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = mdu_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic reset,
  mult_div_sequencer_if.slave bus
);
  state_t state;
  logic op;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] opd;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rmd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic res_neg;
  logic a_neg;
  logic busy;
  logic done;
  logic div_zero;
  assign a_mag = bus.rs[WIDTH-1] ? -bus.rs : bus.rs;
  assign b_mag = bus.rt[WIDTH-1] ? -bus.rt : bus.rt;
  assign prod = res_neg ? -acc : acc;
  assign quo = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  // remainder follows the dividend sign so division truncates toward zero
  assign rmd = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.div_zero = div_zero;
  assign bus.hi = hi;
  assign bus.lo = lo;
  mdu_step_unit #(.WIDTH(WIDTH)) u_step (
    .op(op),
    .acc(acc),
    .operand(opd),
    .acc_next(acc_next)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op <= OP_MULT;
      cnt <= '0;
      acc <= '0;
      opd <= '0;
      res_neg <= 1'b0;
      a_neg <= 1'b0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: if (bus.start_mult || bus.start_div) begin
          op <= bus.start_mult ? OP_MULT : OP_DIV;
          acc <= {{WIDTH{1'b0}}, a_mag};
          opd <= b_mag;
          res_neg <= bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1];
          a_neg <= bus.rs[WIDTH-1];
          cnt <= '0;
          busy <= 1'b1;
          if (!bus.start_mult && bus.rt == '0) begin
            state <= DONE;
            done <= 1'b1;
            div_zero <= 1'b1;
          end else begin
            state <= bus.start_mult ? MULT_RUN : DIV_RUN;
          end
        end
        MULT_RUN, DIV_RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= SIGN_FIX;
        end
        SIGN_FIX: begin
          hi <= (op == OP_MULT) ? prod[2*WIDTH-1:WIDTH] : rmd;
          lo <= (op == OP_MULT) ? prod[WIDTH-1:0] : quo;
          state <= DONE;
          done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: directed-vector checks of latency, results and edge cases.
module tb_mult_div_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int done_cyc, busy_cyc, dz_cnt, done_cnt;
  mult_div_sequencer_if #(.WIDTH(32)) bus ();
  mult_div_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic run_op(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_mult = sm;
    bus.start_div = sd;
    bus.rs = a;
    bus.rt = b;
    @(posedge clk);
    #1;
    bus.start_mult = 1'b0;
    bus.start_div = 1'b0;
    done_cyc = 0;
    busy_cyc = 0;
    dz_cnt = 0;
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (bus.div_zero) dz_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    bus.start_mult = 1'b0;
    bus.start_div = 1'b0;
    bus.rs = '0;
    bus.rt = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_zero}); end
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult;
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    checks++;
    if (busy_cyc !== 34) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 34", busy_cyc); end
    checks++;
    if (done_cyc !== 34 || done_cnt !== 1) begin errors++; $display("FAIL mult_done: got cycle %0d count %0d expected cycle 34 count 1", done_cyc, done_cnt); end
    checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_7x-3: got %h expected FFFFFFFFFFFFFFEB", {bus.hi, bus.lo}); end
    checks++;
    if (dz_cnt !== 0) begin errors++; $display("FAIL mult_div_zero: got %0d expected 0", dz_cnt); end
  endtask

  task automatic test_div;
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (done_cyc !== 34) begin errors++; $display("FAIL div_done_cycle: got %0d expected 34", done_cyc); end
    checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_-7/2: got %h expected FFFFFFFFFFFFFFFD", {bus.hi, bus.lo}); end
  endtask

  task automatic test_div_zero;
    run_op(1'b0, 1'b1, 32'd5, 32'd2);
    checks++;
    if ({bus.hi, bus.lo} !== 64'h00000001_00000002) begin errors++; $display("FAIL div_5/2: got %h expected 0000000100000002", {bus.hi, bus.lo}); end
    run_op(1'b0, 1'b1, 32'd5, 32'd0);
    checks++;
    if (done_cyc !== 1 || done_cnt !== 1) begin errors++; $display("FAIL dz_done: got cycle %0d count %0d expected cycle 1 count 1", done_cyc, done_cnt); end
    checks++;
    if (dz_cnt !== 1 || busy_cyc !== 1) begin errors++; $display("FAIL dz_flag_busy: got dz %0d busy %0d expected 1 1", dz_cnt, busy_cyc); end
    checks++;
    if ({bus.hi, bus.lo} !== 64'h00000001_00000002) begin errors++; $display("FAIL dz_hilo_kept: got %h expected 0000000100000002", {bus.hi, bus.lo}); end
  endtask

  task automatic test_overflow;
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000);
    checks++;
    if ({bus.hi, bus.lo} !== 64'h40000000_00000000) begin errors++; $display("FAIL mult_min_min: got %h expected 4000000000000000", {bus.hi, bus.lo}); end
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if ({bus.hi, bus.lo} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_min_-1: got %h expected 0000000080000000", {bus.hi, bus.lo}); end
    run_op(1'b1, 1'b1, 32'd6, 32'd5);
    checks++;
    if ({bus.hi, bus.lo} !== 64'h00000000_0000001E) begin errors++; $display("FAIL both_starts_mult: got %h expected 000000000000001E", {bus.hi, bus.lo}); end
  endtask

  task automatic test_ignore_busy;
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.rs = 32'd3;
    bus.rt = 32'd4;
    @(posedge clk);
    #1;
    bus.start_mult = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin bus.start_div = 1'b1; bus.rt = 32'd9; end
      if (c == 11) bus.start_div = 1'b0;
      if (bus.done) done_cnt++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL busy_ignore_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if ({bus.hi, bus.lo} !== 64'h00000000_0000000C) begin errors++; $display("FAIL busy_ignore_hilo: got %h expected 000000000000000C", {bus.hi, bus.lo}); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.start_div = 1'b1;
    bus.rs = 32'd100;
    bus.rt = 32'd7;
    @(posedge clk);
    #1;
    bus.start_div = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", bus.busy); end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0) begin errors++; $display("FAIL mid_async_reset: got busy %b hi %h lo %h expected 0 0 0", bus.busy, bus.hi, bus.lo); end
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b1, 1'b0, 32'd2, 32'd3);
    checks++;
    if ({bus.hi, bus.lo} !== 64'h00000000_00000006) begin errors++; $display("FAIL after_reset_mult: got %h expected 0000000000000006", {bus.hi, bus.lo}); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_overflow;
    test_ignore_busy;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
